// File: rtl/exception_ctrl.sv
// Multi-source exception controller for the pipelined LEGv8 core: sticky pending
// requests, fixed-priority take, ERR/ELR/ESR capture, handler mode until ERET.
module exception_ctrl #(
  parameter int XLEN      = 64,
  parameter int NSRC      = 4,
  parameter int CAUSE_W   = 4,
  parameter int VEC_SHIFT = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] exc_req,
  input  logic [NSRC-1:0] exc_mask,
  input  logic            eret,
  input  logic [XLEN-1:0] next_pc,
  input  logic [XLEN-1:0] branch_pc,
  input  logic [XLEN-1:0] vec_base,
  input  logic [1:0]      sys_sel,
  output logic [XLEN-1:0] pc_branch,
  output logic [XLEN-1:0] sys_rdata,
  output logic            eproc,
  output logic [XLEN-1:0] redirect_pc,
  output logic            in_handler,
  output logic [NSRC-1:0] pending
);

  localparam int IDX_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    HANDLER = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   win_idx;
  logic [NSRC-1:0]    act;
  logic [NSRC-1:0]    take_clr;
  logic [XLEN-1:0]    err_q, elr_q;
  logic [CAUSE_W-1:0] esr_q;
  logic [XLEN-1:0]    vec_addr;

  assign act = (pending | exc_req) & exc_mask;

  // Descending scan so the lowest active index is the last, winning, assignment.
  always_comb begin
    // NOTE: a default ahead of every conditional write keeps always_comb latch-free.
    win_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (act[i]) win_idx = IDX_W'(i);
    end
  end

  assign vec_addr = vec_base + (XLEN'(idx) << VEC_SHIFT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!eret && (act != '0)) state_nxt = TAKE;
      TAKE:    state_nxt = HANDLER;
      HANDLER: if (eret) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear mask for the source being taken; a same-cycle request re-sets it below.
  always_comb begin
    take_clr = '0;
    if (state == TAKE) take_clr[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      err_q   <= '0;
      elr_q   <= '0;
      esr_q   <= '0;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      pending <= (pending & ~take_clr) | exc_req;
      if (state == IDLE) idx <= win_idx;
      if (state == TAKE) begin
        err_q <= next_pc;
        elr_q <= vec_addr;
        esr_q <= CAUSE_W'(idx) + CAUSE_W'(1);
      end
    end
  end

  assign eproc       = (state == TAKE) && !reset;
  assign in_handler  = (state != IDLE) && !reset;
  assign redirect_pc = vec_addr;
  // ERET reads the committed ERR, never the value being captured this cycle.
  assign pc_branch   = eret ? err_q : branch_pc;

  always_comb begin
    sys_rdata = '0;
    if (!reset) begin
      case (sys_sel)
        2'b00: sys_rdata = err_q;
        2'b01: sys_rdata = elr_q;
        2'b10: sys_rdata = XLEN'(esr_q);
        2'b11: sys_rdata = XLEN'(pending);
        default: sys_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed scenarios then random traffic,
// all compared against a behavioural mode/pending model.
module tb_exception_ctrl;

  localparam int XLEN = 64;
  localparam int NSRC = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] exc_req, exc_mask;
  logic            eret;
  logic [XLEN-1:0] next_pc, branch_pc, vec_base;
  logic [1:0]      sys_sel;
  logic [XLEN-1:0] pc_branch, sys_rdata, redirect_pc;
  logic            eproc, in_handler;
  logic [NSRC-1:0] pending;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = running, 1 = entering handler, 2 = in handler.
  int              m_mode;
  int              m_src;
  logic [XLEN-1:0] m_err, m_elr;
  int              m_cause;
  logic [NSRC-1:0] m_pend;

  always #5 clk = ~clk;

  exception_ctrl dut (
    .clk(clk), .reset(reset), .exc_req(exc_req), .exc_mask(exc_mask),
    .eret(eret), .next_pc(next_pc), .branch_pc(branch_pc), .vec_base(vec_base),
    .sys_sel(sys_sel), .pc_branch(pc_branch), .sys_rdata(sys_rdata),
    .eproc(eproc), .redirect_pc(redirect_pc), .in_handler(in_handler),
    .pending(pending)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] handler_addr(input int src);
    return vec_base + XLEN'(src) * 128;
  endfunction

  // Let combinational outputs settle and compare them with the model.
  task automatic settle();
    logic [XLEN-1:0] exp_rd;
    #1;
    case (sys_sel)
      2'd0: exp_rd = m_err;
      2'd1: exp_rd = m_elr;
      2'd2: exp_rd = XLEN'(m_cause);
      default: exp_rd = XLEN'(m_pend);
    endcase
    if (reset) exp_rd = '0;
    check("eproc", eproc, !reset && m_mode == 1);
    check("in_handler", in_handler, !reset && m_mode != 0);
    check("pc_branch", pc_branch, eret ? m_err : branch_pc);
    check("sys_rdata", sys_rdata, exp_rd);
    check("pending", pending, m_pend);
    if (!reset && m_mode == 1) check("redirect_pc", redirect_pc, handler_addr(m_src));
  endtask

  // Clock edge, then advance the model with the inputs that were sampled.
  task automatic tick();
    logic [NSRC-1:0] act;
    @(posedge clk);
    if (reset) begin
      m_mode = 0; m_src = 0; m_err = '0; m_elr = '0; m_cause = 0; m_pend = '0;
    end else begin
      act = (m_pend | exc_req) & exc_mask;
      case (m_mode)
        0: begin
          m_pend = m_pend | exc_req;
          if (!eret && act != '0) begin
            m_src = 0;
            while (!act[m_src]) m_src++;
            m_mode = 1;
          end
        end
        1: begin
          m_err   = next_pc;
          m_elr   = handler_addr(m_src);
          m_cause = m_src + 1;
          m_pend  = (m_pend & ~(NSRC'(1) << m_src)) | exc_req;
          m_mode  = 2;
        end
        default: begin
          m_pend = m_pend | exc_req;
          if (eret) m_mode = 0;
        end
      endcase
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  initial begin
    m_mode = 0; m_src = 0; m_err = '0; m_elr = '0; m_cause = 0; m_pend = '0;
    reset = 1'b1; exc_req = 4'b0001; exc_mask = 4'hF; eret = 1'b0;
    next_pc = 64'h40; branch_pc = 64'h200; vec_base = 64'h1000; sys_sel = 2'd0;
    @(negedge clk);

    // Reset: requests ignored, everything reads zero.
    step();
    settle(); check("reset_pending", pending, 0); check("reset_eproc", eproc, 0); tick();
    reset = 1'b0; exc_req = '0;
    step();

    // Single request on source 2.
    exc_req = 4'b0100;
    step();
    exc_req = '0;
    settle(); check("single_eproc", eproc, 1); check("single_redirect", redirect_pc, 64'h1100); tick();
    sys_sel = 2'd0; settle(); check("single_err", sys_rdata, 64'h40); check("single_inh", in_handler, 1); tick();
    sys_sel = 2'd1; settle(); check("single_elr", sys_rdata, 64'h1100); tick();
    sys_sel = 2'd2; settle(); check("single_esr", sys_rdata, 64'h3); check("single_pend", pending, 0); tick();

    // ERET return, then normal branch.
    eret = 1'b1;
    settle(); check("eret_pc", pc_branch, 64'h40); tick();
    eret = 1'b0;
    settle(); check("eret_idle", in_handler, 0); check("branch_pc", pc_branch, 64'h200); tick();

    // Priority: sources 1 and 3 together.
    exc_req = 4'b1010;
    step();
    exc_req = '0;
    settle(); check("prio_redirect", redirect_pc, 64'h1080); tick();
    sys_sel = 2'd2; settle(); check("prio_esr", sys_rdata, 64'h2); tick();
    sys_sel = 2'd3; settle(); check("prio_pend", sys_rdata, 64'h8); tick();
    eret = 1'b1; step();
    eret = 1'b0;
    settle(); check("prio_idle_eproc", eproc, 0); tick();
    settle(); check("prio2_eproc", eproc, 1); check("prio2_redirect", redirect_pc, 64'h1180); tick();
    sys_sel = 2'd2; settle(); check("prio2_esr", sys_rdata, 64'h4); tick();
    eret = 1'b1; step();
    eret = 1'b0;

    // Masked source stays pending until enabled.
    exc_mask = 4'b0000; exc_req = 4'b0001;
    step();
    exc_req = '0;
    settle(); check("mask_eproc", eproc, 0); check("mask_pend", pending, 1); tick();
    exc_mask = 4'b0001;
    step();
    exc_mask = 4'hF;
    settle(); check("unmask_eproc", eproc, 1); tick();
    sys_sel = 2'd2; settle(); check("unmask_esr", sys_rdata, 64'h1); tick();

    // Reset while in handler with a live request.
    reset = 1'b1; exc_req = 4'b0001;
    settle(); check("rst_mid_eproc", eproc, 0); check("rst_mid_rd", sys_rdata, 0); tick();
    reset = 1'b0; exc_req = '0;
    settle(); check("rst_mid_pend", pending, 0); check("rst_mid_inh", in_handler, 0); tick();
    sys_sel = 2'd0; settle(); check("rst_mid_err", sys_rdata, 0); tick();
    settle(); check("rst_mid_quiet", eproc, 0); tick();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 99) == 0);
      exc_req   = ($urandom_range(0, 3) == 0) ? NSRC'($urandom) : '0;
      exc_mask  = ($urandom_range(0, 4) == 0) ? NSRC'($urandom) : '1;
      eret      = ($urandom_range(0, 5) == 0);
      next_pc   = {$urandom, $urandom};
      branch_pc = {$urandom, $urandom};
      vec_base  = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : vec_base;
      sys_sel   = 2'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exception_ctrl.md
Name: exception_ctrl

Overview:
Parametrised multi-source exception controller for the pipelined LEGv8 core. It latches up to NSRC sticky exception requests and picks the highest-priority one. On entry it captures return PC, handler vector and cause into ERR/ELR/ESR. It then holds the core in handler mode until ERET, steers the branch PC (normal branch vs. ERR on ERET), and serves ERR/ELR/ESR/pending reads to the execute stage for MRS-style instructions.

Parameters:
XLEN, 64, datapath/PC width
NSRC, 4, number of exception sources; must satisfy NSRC <= 2**CAUSE_W - 1
CAUSE_W, 4, width of ESR cause field
VEC_SHIFT, 7, log2 of spacing between per-source handler vectors (128 B)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
exc_req  in  NSRC  per-source exception request, level or pulse; bit 0 is highest priority
exc_mask  in  NSRC  1 = source enabled; masked sources stay pending but are not taken
eret  in  1  ERET decoded in execute stage
next_pc  in  XLEN  PC of next instruction (fetch), saved as return address
branch_pc  in  XLEN  normal branch target from execute stage
vec_base  in  XLEN  exception vector base address
sys_sel  in  2  system register read select (instruction bits [13:12])
pc_branch  out  XLEN  branch target to fetch mux
sys_rdata  out  XLEN  system register read data
eproc  out  1  one-cycle pulse: exception taken this cycle (flush + redirect)
redirect_pc  out  XLEN  handler entry address, valid when eproc=1
in_handler  out  1  1 while in handler mode
pending  out  NSRC  sticky pending bits

Behaviour:
- One clock, synchronous active-high reset.
- In a reset cycle, all registers clear and exc_req is ignored:
  - state=IDLE
  - ERR=ELR=0, ESR=0
  - pending=0
  - eproc=0, in_handler=0
- Outputs during reset: pc_branch=branch_pc (eret=0 assumed); sys_rdata=0.
- Pending register: each cycle, pending <= pending | exc_req. The bit of the source taken is cleared in its TAKE cycle. New requests on that same bit in the TAKE cycle are kept (set wins).
- Active set: act = (pending | exc_req) & exc_mask. The winner is the lowest index i with act[i]=1.
- FSM states: IDLE, TAKE, HANDLER.
- IDLE:
  - If act!=0 and eret=0, go to TAKE next cycle and register the winner index.
  - If eret=1, stay IDLE; a stray ERET still redirects to ERR.
- TAKE (exactly 1 cycle):
  - eproc=1.
  - ERR <= next_pc.
  - ELR <= vec_base + (idx << VEC_SHIFT), truncated to XLEN.
  - ESR <= idx+1 in CAUSE_W bits; 0 means no cause.
  - redirect_pc is the same value as ELR, driven combinationally this cycle.
  - Clear pending[idx]; go to HANDLER.
- HANDLER:
  - in_handler=1; no nesting, so new requests only accumulate in pending.
  - When eret=1, go to IDLE.
- ERET priority: ERET in HANDLER with a simultaneous new request means ERET wins. The request is pended and taken 2 cycles later (IDLE, then TAKE).
- pc_branch = eret ? ERR : branch_pc, combinational, in every state. It uses the ERR register value, not a value being written this cycle.
- in_handler: 1 in TAKE and HANDLER, 0 in IDLE.
- sys_rdata, combinational, by sys_sel:
  - 00: ERR
  - 01: ELR
  - 10: ESR zero-extended
  - 11: pending zero-extended
- Latency: request at cycle n (with IDLE at n) gives eproc at n+1 and handler fetch from redirect_pc at n+2.
- Masked-pending: a source masked while pending stays pending and is taken once unmasked and the FSM is in IDLE.
- Reset in TAKE or HANDLER aborts to IDLE with all state cleared; no eproc in the reset cycle.

Test Plan:
- Reset then single request: vec_base=0x1000, next_pc=0x40, exc_req=0b0100 pulse at cycle 3 -> eproc=1 at cycle 4 with redirect_pc=0x1100; then ERR=0x40, ESR=3, in_handler=1, pending=0.
- Priority: exc_req=0b1010 in IDLE -> source 1 taken (ESR=2, ELR=vec_base+0x80); pending=0b1000 afterwards. ERET -> source 3 taken 2 cycles later (ESR=4).
- ERET return: in HANDLER with ERR=0x40, eret=1, branch_pc=0x200 -> pc_branch=0x40 that cycle and IDLE next. With eret=0 -> pc_branch=0x200.
- Mask: exc_mask=0, exc_req pulse bit0 -> no eproc, pending=0b0001. Raising exc_mask[0] -> eproc next cycle, ESR=1.
- Sysreg read: in HANDLER with ERR=0x40, ELR=0x1100, ESR=3, pending=0b1000 -> sys_sel 00/01/10/11 gives 0x40/0x1100/0x3/0x8.
- Reset mid-handler: assert reset in HANDLER while exc_req=0b0001 -> next cycle state IDLE, all registers 0, pending=0. No eproc until a new request after reset is released.
